// File: rtl/draw_scheduler.sv
// Frame draw sequencer: grants four drawing clients in fixed order 0..3 and
// multiplexes the granted client's pixel stream onto one registered plot port.
module draw_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_start,
  input  logic [3:0]  client_mask,
  input  logic [35:0] req_x,
  input  logic [31:0] req_y,
  input  logic [47:0] req_color,
  input  logic [3:0]  req_we,
  input  logic [3:0]  req_done,
  output logic [3:0]  client_start,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [11:0] vga_color,
  output logic        vga_we,
  output logic [1:0]  active_id,
  output logic        busy,
  output logic        frame_done,
  output logic [3:0]  timeout_err,
  output logic        overrun
);

  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    mask_q, mask_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    terr_q, terr_d;
  logic          ovr_q, ovr_d;
  logic [8:0]    vga_x_q;
  logic [7:0]    vga_y_q;
  logic [11:0]   vga_color_q;
  logic          vga_we_q;
  logic [1:0]    sel;

  assign sel = idx_q[1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    timer_d = timer_q;
    terr_d  = terr_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          mask_d  = client_mask;
          idx_d   = '0;
          terr_d  = '0;
          ovr_d   = 1'b0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (idx_q == 3'd4) begin
          state_d = S_DONE;
        end else if (!mask_q[sel]) begin
          idx_d = idx_q + 3'd1;
        end else begin
          timer_d = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // completion takes priority over a coincident timeout
        if (req_done[sel]) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_SELECT;
        end else if (timer_q == TLAST) begin
          terr_d[sel] = 1'b1;
          idx_d       = idx_q + 3'd1;
          state_d     = S_SELECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && frame_start) ovr_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      timer_q     <= '0;
      terr_q      <= '0;
      ovr_q       <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      terr_q      <= terr_d;
      ovr_q       <= ovr_d;
      vga_x_q     <= req_x[9*sel +: 9];
      vga_y_q     <= req_y[8*sel +: 8];
      vga_color_q <= req_color[12*sel +: 12];
      vga_we_q    <= (state_q == S_WAIT) && req_we[sel];
    end
  end

  assign client_start = (state_q == S_LAUNCH) ? (4'b0001 << sel) : '0;
  assign active_id    = ((state_q == S_LAUNCH) || (state_q == S_WAIT)) ? sel : 2'd0;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_DONE);
  assign timeout_err  = terr_q;
  assign overrun      = ovr_q;
  assign vga_x        = vga_x_q;
  assign vga_y        = vga_y_q;
  assign vga_color    = vga_color_q;
  assign vga_we       = vga_we_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: default-timeout instance for sequencing and
// plot forwarding, an 8-cycle-timeout instance for abort behaviour.
module tb_draw_scheduler;

  logic        clock = 1'b0;
  logic        resetn;
  logic        frame_start;
  logic [3:0]  client_mask;
  logic [35:0] req_x;
  logic [31:0] req_y;
  logic [47:0] req_color;
  logic [3:0]  req_we;
  logic [3:0]  req_done;

  logic [3:0]  client_start, t_client_start;
  logic [8:0]  vga_x, t_vga_x;
  logic [7:0]  vga_y, t_vga_y;
  logic [11:0] vga_color, t_vga_color;
  logic        vga_we, t_vga_we;
  logic [1:0]  active_id, t_active_id;
  logic        busy, t_busy;
  logic        frame_done, t_frame_done;
  logic [3:0]  timeout_err, t_timeout_err;
  logic        overrun, t_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  draw_scheduler dut (
    .clock(clock), .resetn(resetn), .frame_start(frame_start), .client_mask(client_mask),
    .req_x(req_x), .req_y(req_y), .req_color(req_color), .req_we(req_we), .req_done(req_done),
    .client_start(client_start), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .vga_we(vga_we), .active_id(active_id), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  draw_scheduler #(.TIMEOUT_CYCLES(8)) dut_t (
    .clock(clock), .resetn(resetn), .frame_start(frame_start), .client_mask(client_mask),
    .req_x(req_x), .req_y(req_y), .req_color(req_color), .req_we(req_we), .req_done(req_done),
    .client_start(t_client_start), .vga_x(t_vga_x), .vga_y(t_vga_y), .vga_color(t_vga_color),
    .vga_we(t_vga_we), .active_id(t_active_id), .busy(t_busy), .frame_done(t_frame_done),
    .timeout_err(t_timeout_err), .overrun(t_overrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] dut_outs();
    return {21'd0, client_start, vga_x, vga_y, vga_color, vga_we, active_id,
            busy, frame_done, timeout_err, overrun};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    frame_start = 1'b0; client_mask = '0; req_x = '0; req_y = '0;
    req_color = '0; req_we = '0; req_done = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  // Launches a frame and plays the clients: each started client pulses done
  // `delay` cycles after its start unless listed in `never`; `noise` done bits are held.
  task automatic run_frame(input bit use_t, input logic [3:0] mask, input logic [3:0] noise,
                           input logic [3:0] never, input int delay, input int budget,
                           output logic [15:0] order, output int nstart, output int cycles,
                           output int bad);
    int cnt, pidx;
    bit pend;
    logic [3:0] cs, dn;
    logic fd;
    order = '0; nstart = 0; cycles = 0; bad = 0; pend = 0; cnt = 0; pidx = 0;
    frame_start = 1'b1; client_mask = mask; req_done = noise;
    for (int c = 1; c <= budget; c++) begin
      tick();
      frame_start = 1'b0;
      cs = use_t ? t_client_start : client_start;
      fd = use_t ? t_frame_done : frame_done;
      if (cnt > 0) cnt--;
      dn = '0;
      if (pend && cnt == 0) begin
        pend = 0;
        if (!never[pidx]) dn[pidx] = 1'b1;
      end
      if (cs != '0) begin
        if (!$onehot(cs)) bad++;
        if (nstart < 4) order[4*nstart +: 4] = cs;
        nstart++;
        pend = 1;
        cnt = delay;
        for (int i = 0; i < 4; i++) if (cs[i]) pidx = i;
      end
      req_done = noise | dn;
      if (fd) begin
        cycles = c;
        break;
      end
    end
    req_done = '0;
  endtask

  initial begin
    logic [15:0] order;
    int nstart, cycles, bad, k;
    logic [3:0] acc;

    resetn = 1'b0;
    clear_inputs();
    #1;
    check("reset_outputs", dut_outs(), 64'd0);
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    check("idle_no_start", {busy, frame_done, client_start}, 6'd0);

    // all four clients, done 10 cycles after each start
    do_reset();
    run_frame(0, 4'b1111, 4'b0000, 4'b0000, 10, 200, order, nstart, cycles, bad);
    check("m1111_order", order, 16'h8421);
    check("m1111_nstart", nstart, 4);
    check("m1111_onehot", bad, 0);
    check("m1111_cycles", cycles, 50);
    check("m1111_terr", timeout_err, 4'b0000);
    tick();
    check("m1111_after", {busy, frame_done}, 2'b00);

    // sparse mask with foreign done pulses held high
    do_reset();
    run_frame(0, 4'b1010, 4'b0101, 4'b0000, 10, 200, order, nstart, cycles, bad);
    check("m1010_order", order, 16'h0082);
    check("m1010_nstart", nstart, 2);
    check("m1010_cycles", cycles, 28);
    tick();
    check("m1010_single_done", frame_done, 1'b0);

    // empty mask: walks every select slot, no launches
    do_reset();
    run_frame(0, 4'b0000, 4'b0000, 4'b0000, 0, 50, order, nstart, cycles, bad);
    check("m0000_nstart", nstart, 0);
    check("m0000_cycles", cycles, 6);

    // timeout on the 8-cycle instance
    do_reset();
    run_frame(1, 4'b0100, 4'b0000, 4'b0100, 0, 60, order, nstart, cycles, bad);
    check("tmo_order", order, 16'h0004);
    check("tmo_cycles", cycles, 15);
    check("tmo_terr", t_timeout_err, 4'b0100);
    tick();
    check("tmo_sticky", t_timeout_err, 4'b0100);
    run_frame(1, 4'b0000, 4'b0000, 4'b0000, 0, 50, order, nstart, cycles, bad);
    check("tmo_cleared", t_timeout_err, 4'b0000);
    check("tmo_next_cycles", cycles, 6);

    // plot forwarding from client 3 while client 0 also strobes
    do_reset();
    req_x     = {9'd100, 18'd0, 9'd7};
    req_y     = {8'd50, 16'd0, 8'd9};
    req_color = {12'hF0F, 24'd0, 12'h123};
    frame_start = 1'b1; client_mask = 4'b1000;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      frame_start = 1'b0;
      if (client_start != '0) begin k = c; break; end
    end
    check("plot_launch_cycle", k, 5);
    check("plot_launch_start", client_start, 4'b1000);
    check("plot_launch_id", active_id, 2'd3);
    req_we = 4'b1001;
    tick();
    check("plot_launch_no_we", vga_we, 1'b0);
    check("plot_wait_id", active_id, 2'd3);
    tick();
    check("plot_pixel", {vga_we, vga_x, vga_y, vga_color}, {1'b1, 9'd100, 8'd50, 12'hF0F});
    req_we = 4'b0001;
    tick();
    check("plot_foreign_we", vga_we, 1'b0);
    req_we = 4'b1000; req_done = 4'b1000;
    tick();
    req_we = '0; req_done = '0;
    check("plot_we_with_done", vga_we, 1'b1);
    check("plot_left_wait", {busy, active_id}, {1'b1, 2'd0});
    tick();
    check("plot_frame_done", frame_done, 1'b1);

    // frame_start and mask change while busy
    do_reset();
    frame_start = 1'b1; client_mask = 4'b0001;
    tick(); frame_start = 1'b0;
    tick();
    check("ovr_launch", client_start, 4'b0001);
    tick();
    check("ovr_before", overrun, 1'b0);
    frame_start = 1'b1; client_mask = 4'b1111;
    tick();
    frame_start = 1'b0;
    check("ovr_set", {overrun, busy, active_id}, {1'b1, 1'b1, 2'd0});
    req_done = 4'b0001;
    tick();
    req_done = '0;
    acc = '0; k = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      acc |= client_start;
      if (frame_done) begin k = c; break; end
    end
    check("ovr_done_cycle", k, 4);
    check("ovr_no_new_start", acc, 4'b0000);
    tick();
    check("ovr_sticky", {overrun, busy}, 2'b10);
    frame_start = 1'b1; client_mask = 4'b0000;
    tick(); frame_start = 1'b0;
    check("ovr_cleared", overrun, 1'b0);

    // asynchronous reset during client 1 wait
    do_reset();
    frame_start = 1'b1; client_mask = 4'b0011;
    tick(); frame_start = 1'b0;
    tick();
    tick();
    req_done = 4'b0001;
    tick();
    req_done = '0;
    tick();
    check("rst_launch1", client_start, 4'b0010);
    tick();
    check("rst_wait1", {busy, active_id}, {1'b1, 2'd1});
    req_x = {18'd0, 9'd5, 9'd0};
    req_we = 4'b0010;
    tick();
    check("rst_pre_we", {vga_we, vga_x}, {1'b1, 9'd5});
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_outs", dut_outs(), 64'd0);
    acc = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      acc[0] = acc[0] | frame_done;
    end
    check("rst_no_frame_done", acc[0], 1'b0);
    clear_inputs();
    resetn = 1'b1;
    tick();
    check("rst_idle_after", busy, 1'b0);
    frame_start = 1'b1; client_mask = 4'b0011;
    tick(); frame_start = 1'b0;
    tick();
    check("rst_restart_c0", client_start, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
